// File: rtl/pset00_clk_utils_if.sv
// Bundle of the derived clock outputs: pass-through, inverted and divided clock.
interface pset00_clk_utils_if;
  logic out_pass;
  logic out_inv;
  logic out_div;

  modport master (output out_pass, output out_inv, output out_div);
  modport slave  (input  out_pass, input  out_inv, input  out_div);
endinterface

// File: rtl/pset00_clk_utils.sv
// Clock utilities: buffered and inverted copies of clk, plus a 50 % duty clock
// divided by DIV_RATIO built from a half-period counter and a toggle flop.
module pset00_clk_utils #(
  parameter int DIV_RATIO = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pset00_clk_utils_if.master clk_o
);

  localparam int HALF  = DIV_RATIO / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

  generate
    if ((DIV_RATIO < 2) || ((DIV_RATIO % 2) != 0)) begin : g_bad_ratio
      $fatal(1, "pset00_clk_utils: DIV_RATIO=%0d must be even and >= 2", DIV_RATIO);
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  // Wrap is explicit at CNT_MAX so non-power-of-two half periods work.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    div_d = div_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      div_d = ~div_q;
    end
  end

  assign clk_o.out_pass = clk;
  assign clk_o.out_inv  = ~clk;
  assign clk_o.out_div  = div_q;

endmodule

// File: tb/tb_pset00_clk_utils.sv
// Directed bench for pset00_clk_utils: DIV_RATIO=2 and DIV_RATIO=6 instances on one clock.
`timescale 1ns/1ps
module tb_pset00_clk_utils;

  logic clk;
  logic rst2_n;
  logic rst6_n;

  pset00_clk_utils_if if2 ();
  pset00_clk_utils_if if6 ();

  pset00_clk_utils #(.DIV_RATIO(2)) dut2 (.clk(clk), .rst_n(rst2_n), .clk_o(if2.master));
  pset00_clk_utils #(.DIV_RATIO(6)) dut6 (.clk(clk), .rst_n(rst6_n), .clk_o(if6.master));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic exp_div2;
    logic exp_div6;
  } vec_t;

  vec_t vecs [12];

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_clk_copies(input string tag);
    check({tag, "_pass2"}, if2.out_pass, clk);
    check({tag, "_inv2"},  if2.out_inv,  ~clk);
    check({tag, "_pass6"}, if6.out_pass, clk);
    check({tag, "_inv6"},  if6.out_inv,  ~clk);
  endtask

  initial begin
    // Expected divider outputs sampled just after rising edges 1..12 after release.
    vecs[0]  = '{1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0};

    rst2_n = 1'b0;
    rst6_n = 1'b0;
    #1;
    check("reset_div2", if2.out_div, 1'b0);
    check("reset_div6", if6.out_div, 1'b0);
    check_clk_copies("reset");
    rst2_n = 1'b1;
    rst6_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("edge%0d_div2", i + 1), if2.out_div, vecs[i].exp_div2);
      check($sformatf("edge%0d_div6", i + 1), if6.out_div, vecs[i].exp_div6);
      check_clk_copies("high");
      @(negedge clk);
      #1;
      check($sformatf("neg%0d_div2", i + 1), if2.out_div, vecs[i].exp_div2);
      check($sformatf("neg%0d_div6", i + 1), if6.out_div, vecs[i].exp_div6);
      check_clk_copies("low");
      $display("vec %0d: div2=%b div6=%b exp %b %b", i + 1, if2.out_div, if6.out_div,
               vecs[i].exp_div2, vecs[i].exp_div6);
    end

    // Edges 13..15: both dividers end high, then reset drops between edges.
    repeat (3) @(posedge clk);
    #1;
    check("prereset_div2", if2.out_div, 1'b1);
    check("prereset_div6", if6.out_div, 1'b1);
    $display("seq async: dividers high at t=%0t, dropping reset", $time);
    rst2_n = 1'b0;
    rst6_n = 1'b0;
    #0.5;
    check("async_div2", if2.out_div, 1'b0);
    check("async_div6", if6.out_div, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("inreset_div2", if2.out_div, 1'b0);
      check("inreset_div6", if6.out_div, 1'b0);
    end

    // Release lands in the NBA region of a rising edge, so that edge still sees reset.
    @(posedge clk);
    rst2_n <= 1'b1;
    rst6_n <= 1'b1;
    #1;
    check("coinc_edge0_div2", if2.out_div, 1'b0);
    check("coinc_edge0_div6", if6.out_div, 1'b0);
    @(posedge clk);
    #1;
    check("coinc_edge1_div2", if2.out_div, 1'b1);
    check("coinc_edge1_div6", if6.out_div, 1'b0);
    @(posedge clk);
    #1;
    check("coinc_edge2_div2", if2.out_div, 1'b0);
    check("coinc_edge2_div6", if6.out_div, 1'b0);
    @(posedge clk);
    #1;
    check("coinc_edge3_div2", if2.out_div, 1'b1);
    check("coinc_edge3_div6", if6.out_div, 1'b1);
    $display("seq coincident release: div2=%b div6=%b", if2.out_div, if6.out_div);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
